// File: rtl/roce_stack_burst_cmd_gen_if.sv
// Bus bundle for the burst command generator: RDMA request, address
// translation request/response, AXI4 AR/AW address channel, completion
// feedback and status. master = generator side, slave = environment side.
interface roce_stack_burst_cmd_gen_if #(
  parameter int unsigned MAX_OUTSTANDING = 8
) ();
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // RDMA request
  logic              s_rdma_req_valid_i;
  logic              s_rdma_req_ready_o;
  logic [63:0]       s_rdma_req_vaddr_i;
  logic [27:0]       s_rdma_req_len_i;
  logic              s_rdma_req_ctl_i;
  // Address translation
  logic              req_addr_valid_o;
  logic              req_addr_ready_i;
  logic [63:0]       req_addr_vaddr_o;
  logic              resp_addr_valid_i;
  logic              resp_addr_ready_o;
  logic [115:0]      resp_addr_data_i;
  // AXI4 address channel
  logic              m_ax_valid_o;
  logic              m_ax_ready_i;
  logic [63:0]       m_ax_addr_o;
  logic [7:0]        m_ax_len_o;
  logic [2:0]        m_ax_size_o;
  logic [1:0]        m_ax_burst_o;
  // Completion and status
  logic              cpl_valid_i;
  logic [CNT_W-1:0]  outstanding_o;
  logic              req_done_o;
  logic              err_o;

  modport master (
    input  s_rdma_req_valid_i, s_rdma_req_vaddr_i, s_rdma_req_len_i, s_rdma_req_ctl_i,
    output s_rdma_req_ready_o,
    output req_addr_valid_o, req_addr_vaddr_o,
    input  req_addr_ready_i,
    input  resp_addr_valid_i, resp_addr_data_i,
    output resp_addr_ready_o,
    output m_ax_valid_o, m_ax_addr_o, m_ax_len_o, m_ax_size_o, m_ax_burst_o,
    input  m_ax_ready_i,
    input  cpl_valid_i,
    output outstanding_o, req_done_o, err_o
  );

  modport slave (
    output s_rdma_req_valid_i, s_rdma_req_vaddr_i, s_rdma_req_len_i, s_rdma_req_ctl_i,
    input  s_rdma_req_ready_o,
    input  req_addr_valid_o, req_addr_vaddr_o,
    output req_addr_ready_i,
    output resp_addr_valid_i, resp_addr_data_i,
    input  resp_addr_ready_o,
    input  m_ax_valid_o, m_ax_addr_o, m_ax_len_o, m_ax_size_o, m_ax_burst_o,
    output m_ax_ready_i,
    output cpl_valid_i,
    input  outstanding_o, req_done_o, err_o
  );
endinterface

// File: rtl/roce_stack_burst_cmd_gen.sv
// RDMA request -> AXI4 INCR address-channel generator. Translates the
// request vaddr, splits the transfer into bursts limited by
// MAX_BURST_BEATS and 4 KB pages, and bounds in-flight bursts.
// The bus interface must be instantiated with the same MAX_OUTSTANDING.
module roce_stack_burst_cmd_gen #(
  parameter int unsigned AXI4_DATA_WIDTH = 512,
  parameter int unsigned MAX_BURST_BEATS = 64,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter bit          READ            = 1'b1  // 1: AR path (cpl = rlast), 0: AW path (cpl = B)
) (
  input logic                        axis_aclk_i,
  input logic                        aresetn_i,
  roce_stack_burst_cmd_gen_if.master bus
);
  localparam int unsigned BYTES      = AXI4_DATA_WIDTH / 8;
  localparam int unsigned OFF_W      = $clog2(BYTES);
  localparam int unsigned CNT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PAGE_BEATS = 4096 / BYTES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_XLATE_REQ,
    S_XLATE_WAIT,
    S_ISSUE,
    S_DRAIN
  } state_e;

  // Beats of the next burst: bounded by remaining beats, the burst cap and
  // the distance to the next 4 KB boundary (addr is BYTES-aligned).
  function automatic logic [8:0] burst_beats(input logic [63:0] addr,
                                             input logic [28:0] rem);
    logic [28:0] nb;
    logic [28:0] page;
    page = 29'(PAGE_BEATS) - 29'(addr[11:OFF_W]);
    nb   = rem;
    if (nb > 29'(MAX_BURST_BEATS)) nb = 29'(MAX_BURST_BEATS);
    if (nb > page)                 nb = page;
    return nb[8:0];
  endfunction

  state_e           r_state, w_state_nxt;
  logic             r_req_ready, r_xreq_valid, r_resp_ready, r_ax_valid;
  logic             r_req_done, r_err;
  logic [63:0]      r_vaddr;
  logic [27:0]      r_len;
  logic             r_ctl;
  logic [63:0]      r_ax_addr;
  logic [7:0]       r_ax_len;
  logic [28:0]      r_beats_rem;   // beats left, including the burst on the bus
  logic [CNT_W-1:0] r_out, w_out_nxt;

  logic             w_req_hs, w_xreq_hs, w_resp_hs, w_ax_hs, w_cpl;
  logic [63:0]      w_paddr, w_first_addr, w_next_addr;
  logic [OFF_W-1:0] w_off;
  logic [28:0]      w_first_beats, w_next_rem;
  logic [8:0]       w_cur_nb, w_first_nb, w_next_nb;
  logic             w_unused;

  assign w_req_hs  = bus.s_rdma_req_valid_i & r_req_ready;
  assign w_xreq_hs = r_xreq_valid & bus.req_addr_ready_i;
  assign w_resp_hs = bus.resp_addr_valid_i & r_resp_ready;
  assign w_ax_hs   = r_ax_valid & bus.m_ax_ready_i;
  assign w_cpl     = bus.cpl_valid_i;

  // First burst: align the physical address down and count covered beats.
  assign w_paddr       = bus.resp_addr_data_i[63:0];
  assign w_off         = w_paddr[OFF_W-1:0];
  assign w_first_addr  = {w_paddr[63:OFF_W], {OFF_W{1'b0}}};
  assign w_first_beats = (29'(r_len) + 29'(w_off) + 29'(BYTES - 1)) >> OFF_W;
  assign w_first_nb    = burst_beats(w_first_addr, w_first_beats);

  // Following burst: advance past the one currently on the bus (wraps mod 2^64).
  assign w_cur_nb    = {1'b0, r_ax_len} + 9'd1;
  assign w_next_addr = r_ax_addr + (64'(w_cur_nb) << OFF_W);
  assign w_next_rem  = r_beats_rem - 29'(w_cur_nb);
  assign w_next_nb   = burst_beats(w_next_addr, w_next_rem);

  // Upper translation-response bits and READ carry no logic.
  assign w_unused = ^{bus.resp_addr_data_i[115:64], READ};

  // In-flight burst count for the next cycle; a stray completion at zero is ignored.
  always_comb begin
    // NOTE: default assigned first so every path drives the signal and no latch is inferred.
    w_out_nxt = r_out;
    unique case ({w_ax_hs, w_cpl})
      2'b10:   w_out_nxt = r_out + CNT_W'(1);
      2'b01:   if (r_out != '0) w_out_nxt = r_out - CNT_W'(1);
      default: w_out_nxt = r_out;
    endcase
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_req_hs) begin
          if (bus.s_rdma_req_len_i == '0)
            w_state_nxt = bus.s_rdma_req_ctl_i ? S_DRAIN : S_IDLE;
          else
            w_state_nxt = S_XLATE_REQ;
        end
      S_XLATE_REQ:  if (w_xreq_hs) w_state_nxt = S_XLATE_WAIT;
      S_XLATE_WAIT: if (w_resp_hs) w_state_nxt = S_ISSUE;
      S_ISSUE:
        if (w_ax_hs && w_next_rem == '0)
          w_state_nxt = r_ctl ? S_DRAIN : S_IDLE;
      S_DRAIN:      if (r_req_done) w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge axis_aclk_i or negedge aresetn_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!aresetn_i) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Handshake outputs registered from the next state so they are glitch-free and low in reset.
  always_ff @(posedge axis_aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_req_ready  <= 1'b0;
      r_xreq_valid <= 1'b0;
      r_resp_ready <= 1'b0;
      r_ax_valid   <= 1'b0;
    end else begin
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_xreq_valid <= (w_state_nxt == S_XLATE_REQ);
      r_resp_ready <= (w_state_nxt == S_XLATE_WAIT);
      // Once raised it holds: the count cannot grow without this handshake.
      r_ax_valid   <= (w_state_nxt == S_ISSUE) && (w_out_nxt < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Latch the accepted request.
  always_ff @(posedge axis_aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_vaddr <= '0;
      r_len   <= '0;
      r_ctl   <= 1'b0;
    end else if (w_req_hs) begin
      r_vaddr <= bus.s_rdma_req_vaddr_i;
      r_len   <= bus.s_rdma_req_len_i;
      r_ctl   <= bus.s_rdma_req_ctl_i;
    end
  end

  // Burst address/length: loaded from translation, advanced on each AXI handshake.
  always_ff @(posedge axis_aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_ax_addr   <= '0;
      r_ax_len    <= '0;
      r_beats_rem <= '0;
    end else if (w_resp_hs) begin
      r_ax_addr   <= w_first_addr;
      r_ax_len    <= 8'(w_first_nb - 9'd1);
      r_beats_rem <= w_first_beats;
    end else if (w_ax_hs) begin
      r_ax_addr   <= w_next_addr;
      r_beats_rem <= w_next_rem;
      if (w_next_rem != '0) r_ax_len <= 8'(w_next_nb - 9'd1);
    end
  end

  // Outstanding counter, sticky error and fence-done pulse.
  always_ff @(posedge axis_aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_out      <= '0;
      r_err      <= 1'b0;
      r_req_done <= 1'b0;
    end else begin
      r_out      <= w_out_nxt;
      if (w_cpl && r_out == '0) r_err <= 1'b1;
      r_req_done <= (r_state == S_DRAIN) && !r_req_done && (w_out_nxt == '0);
    end
  end

  assign bus.s_rdma_req_ready_o = r_req_ready;
  assign bus.req_addr_valid_o   = r_xreq_valid;
  assign bus.req_addr_vaddr_o   = r_vaddr;
  assign bus.resp_addr_ready_o  = r_resp_ready;
  assign bus.m_ax_valid_o       = r_ax_valid;
  assign bus.m_ax_addr_o        = r_ax_addr;
  assign bus.m_ax_len_o         = r_ax_len;
  assign bus.m_ax_size_o        = 3'(OFF_W);
  assign bus.m_ax_burst_o       = 2'b01;
  assign bus.outstanding_o      = r_out;
  assign bus.req_done_o         = r_req_done;
  assign bus.err_o              = r_err;

endmodule
